// File: rtl/dcache_flush_sequencer.sv
// Whole-array invalidation sequencer for the write-through dcache tag/valid SRAM.
// Sweeps every set once after reset and once per accepted flush request.
// While a sweep runs it holds off new lookups. It also waits for outstanding
// refills to drain before it starts a flush sweep.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_INIT  | post-reset sweep, one set per granted cycle, no ack at the end
// ST_IDLE  | normal operation, lookups allowed, waiting for a flush
// ST_DRAIN | flush accepted, waiting for outstanding refills to finish
// ST_SWEEP | flush sweep, one set per granted cycle
// ST_DONE  | one-cycle flush acknowledge
module dcache_flush_sequencer #(
    parameter int NumSets = 256,
    parameter int NumWays = 8,
    parameter int IdxW    = $clog2(NumSets)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_req_i,
    output logic               flush_ack_o,
    input  logic               miss_pending_i,
    output logic               stall_o,
    output logic               init_done_o,
    output logic               tag_req_o,
    input  logic               tag_gnt_i,
    output logic [IdxW-1:0]    tag_idx_o,
    output logic [NumWays-1:0] tag_way_o,
    output logic               tag_we_o
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_DRAIN,
        ST_SWEEP,
        ST_DONE
    } state_t;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSets - 1);

    state_t          state;
    logic [IdxW-1:0] idx;
    logic            pending;
    logic            init_done;

    // Sequencer state, set index, collapsed pending flush and sticky init flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= ST_INIT;
            idx       <= '0;
            pending   <= 1'b0;
            init_done <= 1'b0;
        end else begin
            // A request that arrives outside IDLE is parked. A request that
            // arrives mid-sweep gets its own complete sweep later, because
            // the sets before idx were already invalidated before it arrived.
            if (flush_req_i && (state != ST_IDLE)) begin
                pending <= 1'b1;
            end
            case (state)
                ST_INIT: begin
                    if (tag_gnt_i) begin
                        if (idx == LastIdx) begin
                            idx       <= '0;
                            init_done <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    // A new pulse and a parked request are served by one sweep.
                    if (flush_req_i || pending) begin
                        pending <= 1'b0;
                        state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!miss_pending_i) begin
                        state <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (tag_gnt_i) begin
                        if (idx == LastIdx) begin
                            idx   <= '0;
                            state <= ST_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_INIT;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so no input reaches an output.
    // tag_req_o stays high until granted because only a grant (or reset) leaves
    // INIT/SWEEP, and idx only moves on a grant.
    always_comb begin
        tag_req_o   = (state == ST_INIT) || (state == ST_SWEEP);
        tag_we_o    = tag_req_o;
        tag_way_o   = {NumWays{tag_req_o}};
        tag_idx_o   = idx;
        stall_o     = (state != ST_IDLE);
        flush_ack_o = (state == ST_DONE);
        init_done_o = init_done;
    end

endmodule

// File: tb/tb_dcache_flush_sequencer.sv
// Directed bench for dcache_flush_sequencer with 8 sets and 4 ways.
// Every stimulus step lands 1 ns after the rising edge. Outputs are sampled at
// the same point, so each step is one DUT cycle.
module tb_dcache_flush_sequencer;

    localparam int NumSets = 8;
    localparam int NumWays = 4;
    localparam int IdxW    = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush_req;
    logic               flush_ack;
    logic               miss_pending;
    logic               stall;
    logic               init_done;
    logic               tag_req;
    logic               tag_gnt;
    logic [IdxW-1:0]    tag_idx;
    logic [NumWays-1:0] tag_way;
    logic               tag_we;

    int errors = 0;
    int checks = 0;

    // Running totals of granted writes, per-index writes and acks.
    int wr_count = 0;
    int ack_count = 0;
    int hist [NumSets];

    int wr0;
    int ack0;
    int h0 [NumSets];

    dcache_flush_sequencer #(
        .NumSets(NumSets),
        .NumWays(NumWays)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_req_i   (flush_req),
        .flush_ack_o   (flush_ack),
        .miss_pending_i(miss_pending),
        .stall_o       (stall),
        .init_done_o   (init_done),
        .tag_req_o     (tag_req),
        .tag_gnt_i     (tag_gnt),
        .tag_idx_o     (tag_idx),
        .tag_way_o     (tag_way),
        .tag_we_o      (tag_we)
    );

    always #5 clk = ~clk;

    // Count every granted SRAM write and every ack at mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tag_req && tag_gnt) begin
                wr_count++;
                hist[tag_idx]++;
            end
            if (flush_ack) ack_count++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Eight consecutive fully granted sweep cycles with indices 0..7.
    task automatic sweep_full(input string tag);
        for (int i = 0; i < NumSets; i++) begin
            step;
            check({tag, "_req"}, 32'(tag_req), 32'd1);
            check({tag, "_idx"}, 32'(tag_idx), 32'(i));
            check({tag, "_way"}, 32'(tag_way), 32'hF);
        end
    endtask

    task automatic snap;
        wr0  = wr_count;
        ack0 = ack_count;
        for (int i = 0; i < NumSets; i++) h0[i] = hist[i];
    endtask

    initial begin
        for (int i = 0; i < NumSets; i++) hist[i] = 0;
        rst_n        = 1'b0;
        flush_req    = 1'b0;
        miss_pending = 1'b0;
        tag_gnt      = 1'b1;

        // Reset held: the machine is stalled, no ack, init not done.
        step;
        step;
        check("rst_stall", 32'(stall), 32'd1);
        check("rst_ack", 32'(flush_ack), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);

        // Release: cycle 0 is the first cycle with rst_n high.
        rst_n = 1'b1;
        snap;
        check("init_req0", 32'(tag_req), 32'd1);
        check("init_idx0", 32'(tag_idx), 32'd0);
        check("init_way0", 32'(tag_way), 32'hF);
        check("init_we0", 32'(tag_we), 32'd1);
        for (int i = 1; i < NumSets; i++) begin
            step;
            check("init_idx", 32'(tag_idx), 32'(i));
            check("init_done_early", 32'(init_done), 32'd0);
        end
        step;
        check("init_done_c8", 32'(init_done), 32'd1);
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_req", 32'(tag_req), 32'd0);
        check("idle_way", 32'(tag_way), 32'h0);
        check("init_no_ack", 32'(ack_count - ack0), 32'd0);

        // Flush with no misses and full grant: ack at t+10.
        flush_req = 1'b1;
        step;
        flush_req = 1'b0;
        check("fl_stall_t1", 32'(stall), 32'd1);
        check("fl_req_t1", 32'(tag_req), 32'd0);
        sweep_full("fl");
        step;
        check("fl_ack_t10", 32'(flush_ack), 32'd1);
        check("fl_stall_t10", 32'(stall), 32'd1);
        step;
        check("fl_ack_t11", 32'(flush_ack), 32'd0);
        check("fl_stall_t11", 32'(stall), 32'd0);

        // Refills outstanding for 5 cycles after the request: ack at t+15.
        flush_req    = 1'b1;
        miss_pending = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step;
            flush_req = 1'b0;
            if (k == 6) miss_pending = 1'b0;
            check("mp_no_req", 32'(tag_req), 32'd0);
            check("mp_stall", 32'(stall), 32'd1);
        end
        sweep_full("mp");
        step;
        check("mp_ack_t15", 32'(flush_ack), 32'd1);
        step;
        check("mp_idle", 32'(stall), 32'd0);

        // Grant withheld on alternate cycles: idx holds, 16 sweep cycles.
        snap;
        flush_req = 1'b1;
        step;
        flush_req = 1'b0;
        tag_gnt   = 1'b0;
        for (int c = 0; c < 16; c++) begin
            step;
            tag_gnt = (c % 2 == 1);
            check("alt_req", 32'(tag_req), 32'd1);
            check("alt_idx", 32'(tag_idx), 32'(c / 2));
        end
        step;
        tag_gnt = 1'b1;
        check("alt_ack", 32'(flush_ack), 32'd1);
        check("alt_writes", 32'(wr_count - wr0), 32'd8);
        for (int i = 0; i < NumSets; i++) check("alt_each_idx", 32'(hist[i] - h0[i]), 32'd1);
        step;

        // Reset, one pulse during INIT, two pulses while SWEEP sits at idx 3.
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        snap;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step;
            flush_req = (cyc == 2) || (cyc == 13) || (cyc == 15);
            tag_gnt   = !((cyc == 13) || (cyc == 14));
            case (cyc)
                1:  check("mx_init_done0", 32'(init_done), 32'd0);
                8:  check("mx_idle_c8", 32'(stall), 32'd0);
                9:  check("mx_drain_c9", 32'(tag_req), 32'd0);
                13: check("mx_idx3_a", 32'(tag_idx), 32'd3);
                15: check("mx_idx3_b", 32'(tag_idx), 32'd3);
                16: check("mx_idx4", 32'(tag_idx), 32'd4);
                20: check("mx_ack1", 32'(flush_ack), 32'd1);
                21: check("mx_idle_one", 32'(stall), 32'd0);
                22: check("mx_drain2", 32'(tag_req), 32'd0);
                23: check("mx_sweep2_idx0", 32'(tag_idx), 32'd0);
                31: check("mx_ack2", 32'(flush_ack), 32'd1);
                32: check("mx_idle_end", 32'(stall), 32'd0);
                default: ;
            endcase
        end
        check("mx_acks", 32'(ack_count - ack0), 32'd2);
        check("mx_writes", 32'(wr_count - wr0), 32'd24);
        for (int i = 0; i < NumSets; i++) check("mx_each_idx", 32'(hist[i] - h0[i]), 32'd3);

        // Reset for one cycle at idx 5 of a sweep aborts it without an ack.
        snap;
        flush_req = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step;
            flush_req = 1'b0;
        end
        check("ab_idx5", 32'(tag_idx), 32'd5);
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        check("ab_init_idx", 32'(tag_idx), 32'd0);
        check("ab_init_req", 32'(tag_req), 32'd1);
        check("ab_init_done", 32'(init_done), 32'd0);
        check("ab_stall", 32'(stall), 32'd1);
        for (int k = 1; k < NumSets; k++) step;
        for (int k = 0; k < 6; k++) begin
            step;
            check("ab_idle_stays", 32'(stall), 32'd0);
        end
        check("ab_init_done_end", 32'(init_done), 32'd1);
        check("ab_no_ack", 32'(ack_count - ack0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
